mips_debug_ctrl: RTL and testbench
==================================

MIPS_DEBUG_CTRL -- requirements
Module: mips_debug_ctrl

Interface
REQ-001 SHALL have parameter LEN, default 32, meaning instruction/word width.
REQ-002 SHALL have parameter RAM_DEPTH_PROGRAM, default 32, meaning program memory depth in words.
REQ-003 SHALL have parameter NB_CYCLES, default 32, meaning cycle counter width.
REQ-004 SHALL have port i_clk, input, 1, meaning single system clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst, input, 1, meaning reset: asynchronous, active-low.
REQ-006 SHALL have ports i_rx_data, input, 8, received byte; i_rx_valid, input, 1, byte valid; o_rx_ready, output, 1, byte accepted when valid and ready are high.
REQ-007 SHALL have port i_if_id_instr, input, LEN, meaning instruction currently in the IF/ID latch.
REQ-008 SHALL have ports o_preload_flag (1), o_preload_address (LEN) and o_preload_instruction (LEN), all outputs, meaning the program-memory write strobe, address and data.
REQ-009 SHALL have ports o_mips_rst (1) and o_step_mode_flag (1), both outputs; o_mips_rst is the active-low core reset and o_step_mode_flag is the step-mode enable.
REQ-010 SHALL have port o_step, output, 1, meaning a one-cycle core step pulse.
REQ-011 SHALL have ports o_cycle_count (NB_CYCLES), o_done (1) and o_load_full (1), all outputs.

Function
REQ-012 SHALL implement the states LOAD, WAIT_CMD, RUN, STEP and DONE.
REQ-013 In LOAD: o_rx_ready=1, o_mips_rst=0, o_step_mode_flag=0; bytes are assembled MSB-first into LEN-bit words.
REQ-014 On the 4th accepted byte: o_preload_flag=1 for exactly one cycle, with o_preload_address equal to the current address and o_preload_instruction equal to the word; the address then increments by 1.
REQ-015 If the word is HALT_WORD (32'hFFFFFFFF), it SHALL still be written, and the next state is WAIT_CMD.
REQ-016 If a non-halt word is written at address RAM_DEPTH_PROGRAM-1, o_load_full SHALL be set (sticky until the next LOAD entry) and the next state is WAIT_CMD; the address never wraps.
REQ-017 In WAIT_CMD: o_mips_rst=1, o_step_mode_flag=1, o_rx_ready=1. Commands:
- 8'h52 ('R') -> RUN.
- 8'h53 ('S') -> STEP.
- any other byte is consumed and ignored.
REQ-018 In STEP: o_step=1 for one cycle, which counts as one enabled cycle; the next state is WAIT_CMD.
REQ-019 In RUN: o_step_mode_flag=0, o_rx_ready=0, and every cycle is an enabled cycle.
REQ-020 On every enabled cycle, o_cycle_count SHALL increment, saturating at all-ones.
REQ-021 Halt drain:
- the drain counter (0..4) increments on an enabled cycle when i_if_id_instr==HALT_WORD or the drain counter is nonzero;
- when it reaches DRAIN_CYCLES=4 -> DONE.
REQ-022 In DONE:
- o_done=1, o_step_mode_flag=1, o_rx_ready=1; o_cycle_count is frozen.
- Byte 8'h4C ('L') -> LOAD, clearing address, drain counter, o_cycle_count, o_done and o_load_full, and holding the core in reset.
- Other bytes are ignored.
REQ-023 A partially assembled word SHALL be discarded on any exit from LOAD.
REQ-024 A halt seen on the same cycle as a STEP pulse SHALL count toward the drain.

Reset
REQ-025 While i_rst=0, state=LOAD, o_preload_flag=0, o_preload_address=0, o_preload_instruction=0, o_mips_rst=0, o_step_mode_flag=0, o_step=0, o_cycle_count=0, o_done=0, o_load_full=0, byte index=0 and drain counter=0.
REQ-026 Reset asserted mid-RUN or mid-LOAD SHALL abort immediately, with no further preload write or step pulse.

Structure
REQ-027 Package mips_dbg_pkg SHALL hold the state encoding, HALT_WORD, DRAIN_CYCLES and the command byte constants CMD_RUN, CMD_STEP and CMD_LOAD.
REQ-028 One sub-module, word_assembler, SHALL convert 4 bytes to a LEN-bit word with a word-valid pulse and a clear input.

Verification
REQ-029 Load test: send bytes 20,01,00,05 then FF,FF,FF,FF -> writes at address 0 (32'h20010005) and address 1 (32'hFFFFFFFF); state WAIT_CMD; o_mips_rst=1.
REQ-030 Run test: after the load above, send 'R' with the halt at IF/ID on enabled cycle 2 -> o_done after 4 more cycles; o_cycle_count=6 and stays frozen.
REQ-031 Step test: 'S' three times -> exactly three single-cycle o_step pulses; o_cycle_count=3; o_step_mode_flag stays 1.
REQ-032 Full test: 32 non-halt words -> o_load_full=1, last write at address 31, no write at address 32.
REQ-033 Reset test: i_rst low mid-RUN, then 'L' from DONE after re-run -> all outputs return to their reset values and the address restarts at 0.

Source files
------------

// File: rtl/mips_dbg_pkg.sv
// rtl/mips_dbg_pkg.sv - shared state encoding and constants for the MIPS debug controller
package mips_dbg_pkg;

    typedef enum logic [2:0] {
        ST_LOAD     = 3'd0,
        ST_WAIT_CMD = 3'd1,
        ST_RUN      = 3'd2,
        ST_STEP     = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam logic [31:0] HALT_WORD    = 32'hFFFF_FFFF;
    localparam int          DRAIN_CYCLES = 4;

    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_LOAD = 8'h4C;

endpackage

// File: rtl/mips_debug_ctrl_if.sv
// rtl/mips_debug_ctrl_if.sv - received-byte stream and program-memory preload bus
interface mips_debug_ctrl_if #(
    parameter int LEN = 32
);
    logic [7:0]     i_rx_data;
    logic           i_rx_valid;
    logic           o_rx_ready;
    logic           o_preload_flag;
    logic [LEN-1:0] o_preload_address;
    logic [LEN-1:0] o_preload_instruction;

    modport master (
        output i_rx_data, i_rx_valid,
        input  o_rx_ready, o_preload_flag, o_preload_address, o_preload_instruction
    );

    modport slave (
        input  i_rx_data, i_rx_valid,
        output o_rx_ready, o_preload_flag, o_preload_address, o_preload_instruction
    );
endinterface

// File: rtl/mips_debug_ctrl_word_assembler.sv
// rtl/mips_debug_ctrl_word_assembler.sv - packs MSB-first bytes into LEN-bit words
module word_assembler #(
    parameter int LEN = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic [7:0]     byte_data,
    input  logic           byte_valid,
    output logic [LEN-1:0] word,
    output logic           word_valid
);
    localparam int NB = LEN / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    logic [LEN-9:0] shreg;
    logic [IW-1:0]  idx;

    // The completed word is presented combinationally on the last byte so the
    // controller can write it and change state on the same edge.
    assign word       = {shreg, byte_data};
    assign word_valid = byte_valid && (idx == IW'(NB - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            idx   <= '0;
        end else if (clear) begin
            shreg <= '0;
            idx   <= '0;
        end else if (byte_valid) begin
            shreg <= word[LEN-9:0];
            idx   <= word_valid ? '0 : idx + IW'(1);
        end
    end
endmodule

// File: rtl/mips_debug_ctrl.sv
// rtl/mips_debug_ctrl.sv - debug loader/run/step controller for a MIPS core
module mips_debug_ctrl
    import mips_dbg_pkg::*;
#(
    parameter int LEN               = 32,
    parameter int RAM_DEPTH_PROGRAM = 32,
    parameter int NB_CYCLES         = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    mips_debug_ctrl_if.slave     bus,
    input  logic [LEN-1:0]       i_if_id_instr,
    output logic                 o_mips_rst,
    output logic                 o_step_mode_flag,
    output logic                 o_step,
    output logic [NB_CYCLES-1:0] o_cycle_count,
    output logic                 o_done,
    output logic                 o_load_full
);
    state_t         state, state_next;
    logic [LEN-1:0] addr;
    logic [2:0]     drain;
    logic [LEN-1:0] word;
    logic           word_valid;
    logic           rx_ready;
    logic           preload_flag;
    logic [LEN-1:0] preload_address;
    logic [LEN-1:0] preload_instruction;

    logic load_accept, cmd_accept, enabled, drain_hit, drain_last;
    logic word_is_halt, last_slot, load_cmd;

    assign load_accept  = (state == ST_LOAD) && bus.i_rx_valid;
    assign cmd_accept   = bus.i_rx_valid && rx_ready;
    assign enabled      = (state == ST_RUN) || (state == ST_STEP);
    assign drain_hit    = enabled && ((i_if_id_instr == LEN'(HALT_WORD)) || (drain != 3'd0));
    assign drain_last   = drain_hit && (drain == 3'(DRAIN_CYCLES - 1));
    assign word_is_halt = (word == LEN'(HALT_WORD));
    assign last_slot    = (addr == LEN'(RAM_DEPTH_PROGRAM - 1));
    assign load_cmd     = (state == ST_DONE) && cmd_accept && (bus.i_rx_data == CMD_LOAD);

    // Held in clear outside LOAD so any partial word is dropped on exit.
    word_assembler #(.LEN(LEN)) u_asm (
        .clk        (i_clk),
        .rst_n      (i_rst),
        .clear      (state != ST_LOAD),
        .byte_data  (bus.i_rx_data),
        .byte_valid (load_accept),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= ST_LOAD;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD:     if (word_valid && (word_is_halt || last_slot)) state_next = ST_WAIT_CMD;
            ST_WAIT_CMD: if (cmd_accept) begin
                             if (bus.i_rx_data == CMD_RUN)       state_next = ST_RUN;
                             else if (bus.i_rx_data == CMD_STEP) state_next = ST_STEP;
                         end
            ST_RUN:      if (drain_last) state_next = ST_DONE;
            ST_STEP:     state_next = drain_last ? ST_DONE : ST_WAIT_CMD;
            ST_DONE:     if (load_cmd) state_next = ST_LOAD;
            default:     state_next = ST_LOAD;
        endcase
    end

    always_comb begin
        rx_ready         = 1'b1;
        o_mips_rst       = 1'b1;
        o_step_mode_flag = 1'b1;
        o_step           = 1'b0;
        o_done           = 1'b0;
        case (state)
            ST_LOAD: begin
                o_mips_rst       = 1'b0;
                o_step_mode_flag = 1'b0;
            end
            ST_RUN: begin
                rx_ready         = 1'b0;
                o_step_mode_flag = 1'b0;
            end
            ST_STEP: begin
                rx_ready = 1'b0;
                o_step   = 1'b1;
            end
            ST_DONE: o_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            addr                <= '0;
            drain               <= '0;
            o_cycle_count       <= '0;
            o_load_full         <= 1'b0;
            preload_flag        <= 1'b0;
            preload_address     <= '0;
            preload_instruction <= '0;
        end else begin
            preload_flag <= 1'b0;
            if (load_accept && word_valid) begin
                preload_flag        <= 1'b1;
                preload_address     <= addr;
                preload_instruction <= word;
                addr                <= addr + LEN'(1);
                if (!word_is_halt && last_slot) o_load_full <= 1'b1;
            end
            if (enabled && (o_cycle_count != {NB_CYCLES{1'b1}}))
                o_cycle_count <= o_cycle_count + NB_CYCLES'(1);
            if (drain_hit) drain <= drain + 3'd1;
            if (load_cmd) begin
                addr                <= '0;
                drain               <= '0;
                o_cycle_count       <= '0;
                o_load_full         <= 1'b0;
                preload_address     <= '0;
                preload_instruction <= '0;
            end
        end
    end

    assign bus.o_rx_ready            = rx_ready;
    assign bus.o_preload_flag        = preload_flag;
    assign bus.o_preload_address     = preload_address;
    assign bus.o_preload_instruction = preload_instruction;
endmodule

// File: tb/tb_mips_debug_ctrl.sv
// tb/tb_mips_debug_ctrl.sv - self-checking bench for mips_debug_ctrl
module tb_mips_debug_ctrl;
    import mips_dbg_pkg::*;

    localparam int LEN   = 32;
    localparam int DEPTH = 32;
    localparam int NBC   = 32;
    localparam int M_LOAD = 0, M_WAIT = 1, M_RUN = 2, M_DONE = 3;

    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
    typedef struct { logic [7:0] cmd; int exp_count; bit exp_sm; bit exp_ready; bit exp_done; } vec_t;

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b0;
    logic [LEN-1:0] i_if_id_instr;
    logic           o_mips_rst, o_step_mode_flag, o_step, o_done, o_load_full;
    logic [NBC-1:0] o_cycle_count;

    mips_debug_ctrl_if #(.LEN(LEN)) bus ();

    mips_debug_ctrl #(.LEN(LEN), .RAM_DEPTH_PROGRAM(DEPTH), .NB_CYCLES(NBC)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .bus              (bus),
        .i_if_id_instr    (i_if_id_instr),
        .o_mips_rst       (o_mips_rst),
        .o_step_mode_flag (o_step_mode_flag),
        .o_step           (o_step),
        .o_cycle_count    (o_cycle_count),
        .o_done           (o_done),
        .o_load_full      (o_load_full)
    );

    always #5 i_clk = ~i_clk;

    int  checks = 0;
    int  errors = 0;
    int  step_pulses = 0;
    wr_t got_q[$];
    wr_t exp_q[$];
    wr_t mon_w;

    // reference model state
    int         m_mode;
    logic [7:0] m_bytes[$];
    int         m_addr;
    longint     m_count;
    int         m_drain;
    bit         m_full;

    always @(negedge i_clk) begin
        if (bus.o_preload_flag) begin
            mon_w.a = bus.o_preload_address;
            mon_w.d = bus.o_preload_instruction;
            got_q.push_back(mon_w);
        end
        if (o_step) step_pulses++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void m_reset();
        m_mode = M_LOAD;
        m_bytes.delete();
        m_addr  = 0;
        m_count = 0;
        m_drain = 0;
        m_full  = 0;
    endfunction

    function automatic void m_enabled(input logic [31:0] instr);
        m_count++;
        if (instr == HALT_WORD || m_drain > 0) m_drain++;
        if (m_drain == DRAIN_CYCLES) m_mode = M_DONE;
    endfunction

    function automatic void m_byte(input logic [7:0] b, input logic [31:0] instr);
        logic [31:0] w;
        wr_t e;
        case (m_mode)
            M_LOAD: begin
                m_bytes.push_back(b);
                if (m_bytes.size() == 4) begin
                    w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                    m_bytes.delete();
                    e.a = 32'(m_addr);
                    e.d = w;
                    exp_q.push_back(e);
                    m_addr++;
                    if (w == HALT_WORD) m_mode = M_WAIT;
                    else if (m_addr == DEPTH) begin
                        m_full = 1;
                        m_mode = M_WAIT;
                    end
                end
            end
            M_WAIT: begin
                if (b == CMD_RUN) m_mode = M_RUN;
                else if (b == CMD_STEP) m_enabled(instr);
            end
            M_DONE: if (b == CMD_LOAD) m_reset();
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] rnd_nonhalt();
        logic [31:0] v;
        v = $urandom();
        return (v == HALT_WORD) ? 32'h0 : v;
    endfunction

    task automatic settle(input int n);
        repeat (n) @(negedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        while (!bus.o_rx_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 200) begin
            check("rx_ready_timeout", 0, 1);
            bus.i_rx_valid = 1'b0;
        end else begin
            @(posedge i_clk);
            #1;
            bus.i_rx_valid = 1'b0;
            m_byte(b, i_if_id_instr);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic compare_writes(input string tag);
        wr_t g, e;
        check({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_addr"}, g.a, e.a);
            check({tag, "_data"}, g.d, e.d);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_status(input string tag);
        check({tag, "_mips_rst"},  o_mips_rst,       m_mode != M_LOAD);
        check({tag, "_step_mode"}, o_step_mode_flag, m_mode == M_WAIT || m_mode == M_DONE);
        check({tag, "_rx_ready"},  bus.o_rx_ready,   m_mode != M_RUN);
        check({tag, "_done"},      o_done,           m_mode == M_DONE);
        check({tag, "_count"},     o_cycle_count,    32'(m_count));
        check({tag, "_full"},      o_load_full,      m_full);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pl_flag"},   bus.o_preload_flag,        0);
        check({tag, "_pl_addr"},   bus.o_preload_address,     0);
        check({tag, "_pl_instr"},  bus.o_preload_instruction, 0);
        check({tag, "_mips_rst"},  o_mips_rst,                0);
        check({tag, "_step_mode"}, o_step_mode_flag,          0);
        check({tag, "_step"},      o_step,                    0);
        check({tag, "_count"},     o_cycle_count,             0);
        check({tag, "_done"},      o_done,                    0);
        check({tag, "_full"},      o_load_full,               0);
        check({tag, "_rx_ready"},  bus.o_rx_ready,            1);
    endtask

    task automatic run_until_done(input string tag, input longint halt_at);
        bit early;
        early = 0;
        for (int k = 0; k < 60 && m_mode != M_DONE; k++) begin
            i_if_id_instr = (m_count == halt_at) ? HALT_WORD : rnd_nonhalt();
            @(posedge i_clk);
            m_enabled(i_if_id_instr);
            #1;
            if (m_mode != M_DONE && (o_done || bus.o_rx_ready || o_step_mode_flag)) early = 1;
        end
        i_if_id_instr = '0;
        check({tag, "_run_outputs_ok"}, early, 0);
        check({tag, "_reached_done"}, m_mode == M_DONE, 1);
        check({tag, "_done"}, o_done, 1);
    endtask

    initial begin
        vec_t vecs[6];
        logic [7:0] b;

        vecs[0] = '{8'h00,   0, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{CMD_STEP, 1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{CMD_LOAD, 1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{CMD_STEP, 2, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h7F,   2, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{CMD_STEP, 3, 1'b1, 1'b1, 1'b0};

        bus.i_rx_data  = '0;
        bus.i_rx_valid = 1'b0;
        i_if_id_instr  = '0;
        m_reset();
        settle(3);
        check_reset_outputs("reset");
        @(negedge i_clk);
        i_rst = 1'b1;

        // load: one instruction then the halt word
        send_word(32'h2001_0005);
        send_word(HALT_WORD);
        settle(2);
        check("load_last_addr", bus.o_preload_address, 1);
        check("load_last_instr", bus.o_preload_instruction, 32'hFFFF_FFFF);
        check("load_mips_rst", o_mips_rst, 1);
        check_status("load");
        compare_writes("load");

        // run with halt at IF/ID when the count is 2
        send_byte(CMD_RUN);
        run_until_done("run", 2);
        check("run_count", o_cycle_count, 6);
        repeat (5) begin
            i_if_id_instr = rnd_nonhalt();
            @(negedge i_clk);
        end
        i_if_id_instr = '0;
        check("run_count_frozen", o_cycle_count, 6);
        check_status("run_done");

        send_byte(CMD_LOAD);
        settle(1);
        check_reset_outputs("after_load_cmd");

        // step table
        send_word(rnd_nonhalt());
        send_word(HALT_WORD);
        settle(1);
        compare_writes("load2");
        step_pulses = 0;
        for (int i = 0; i < 6; i++) begin
            send_byte(vecs[i].cmd);
            settle(2);
            check($sformatf("vec%0d_count", i), o_cycle_count, 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_step_mode", i), o_step_mode_flag, vecs[i].exp_sm);
            check($sformatf("vec%0d_rx_ready", i), bus.o_rx_ready, vecs[i].exp_ready);
            check($sformatf("vec%0d_done", i), o_done, vecs[i].exp_done);
            check_status($sformatf("vec%0d", i));
        end
        check("step_pulses", step_pulses, 3);

        // random command bytes, occasional halt at IF/ID during steps
        for (int i = 0; i < 24; i++) begin
            b = ($urandom_range(0, 2) == 0) ? CMD_STEP : 8'($urandom_range(0, 255));
            if (b == CMD_RUN) b = CMD_STEP;
            i_if_id_instr = ($urandom_range(0, 7) == 0) ? HALT_WORD : rnd_nonhalt();
            send_byte(b);
            settle(2);
            check_status($sformatf("rnd%0d", i));
        end
        i_if_id_instr = '0;
        for (int g = 0; g < 20 && m_mode != M_WAIT; g++) begin
            if (m_mode == M_DONE) send_byte(CMD_LOAD);
            else send_byte(8'hFF);
        end
        send_byte(CMD_RUN);
        run_until_done("rnd_run", m_count + 1);
        settle(1);
        compare_writes("rnd");

        // fill the whole program memory with non-halt words
        send_byte(CMD_LOAD);
        for (int i = 0; i < DEPTH; i++) send_word(rnd_nonhalt());
        settle(2);
        check("full_flag", o_load_full, 1);
        check("full_last_addr", bus.o_preload_address, DEPTH - 1);
        check_status("full");
        compare_writes("full");
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        settle(2);
        check_status("full_after");
        compare_writes("full_nowrap");

        // reset mid-RUN
        send_byte(CMD_RUN);
        for (int i = 0; i < 3; i++) begin
            i_if_id_instr = rnd_nonhalt();
            @(posedge i_clk);
            m_enabled(i_if_id_instr);
        end
        #1;
        i_rst = 1'b0;
        m_reset();
        #1;
        check_reset_outputs("rst_run");
        step_pulses = 0;
        settle(2);
        check("rst_run_no_step", step_pulses, 0);
        i_rst = 1'b1;
        i_if_id_instr = '0;

        // reset mid-LOAD discards the partial word
        send_byte(8'hAB);
        send_byte(8'hCD);
        i_rst = 1'b0;
        m_reset();
        settle(1);
        i_rst = 1'b1;
        send_word(32'h2001_0005);
        send_word(HALT_WORD);
        settle(1);
        compare_writes("rst_load");
        send_byte(CMD_RUN);
        run_until_done("rerun", m_count + 1);
        send_byte(CMD_LOAD);
        settle(1);
        check_reset_outputs("after_rerun_load");
        send_word(HALT_WORD);
        settle(1);
        check("restart_addr", bus.o_preload_address, 0);
        compare_writes("restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
